// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, the canonical NOP and the
// IF/ID boundary record consumed by decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request outstanding to imem and
// feeds IF/ID through a one-entry skid buffer; execute redirects flush it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic         req_valid_q, req_valid_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  if_id_t       if_id_q, if_id_d;
  logic         req_fire_s;
  logic         slot_free_s;
  logic         redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Next-state logic: redirect overrides normal fetch sequencing
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if_id_d     = if_id_q;
    req_fire_s  = req_valid_q && imem_req_ready;
    slot_free_s = !if_id_q.valid || id_ready;

    if (if_id_q.valid && id_ready) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else begin
      if_id_d.valid = if_id_q.valid;
    end

    if (redirect_valid) begin
      pc_d          = {redirect_pc[31:2], 2'b00};
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
      buf_valid_d   = 1'b0;
      case (state_q)
        REQ: begin
          if (req_fire_s) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        // A response arriving with the redirect is simply the one to drop
        WAIT: begin
          if (imem_rsp_valid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: begin
          state_d = REQ;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        REQ: begin
          if (req_fire_s) begin
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (!imem_rsp_valid) begin
            state_d = WAIT;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (slot_free_s) begin
            if_id_d = '{valid: 1'b1, instr: imem_rsp_data, pc: pc_q, pc_plus4: pc_q + 32'd4};
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end else begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rsp_data;
            buf_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (id_ready && buf_valid_q) begin
            if_id_d     = '{valid: 1'b1, instr: buf_instr_q, pc: buf_pc_q, pc_plus4: buf_pc_q + 32'd4};
            buf_valid_d = 1'b0;
            state_d     = REQ;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = REQ;
          kill_d  = 1'b0;
        end
      endcase
    end

    req_valid_d = (state_d == REQ);
  end

  // State and output registers; request valid is held low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
      if_id_q     <= '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd4};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      if_id_q     <= if_id_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign id_valid       = if_id_q.valid;
  assign id_instr       = if_id_q.instr;
  assign id_pc          = if_id_q.pc;
  assign id_pc_plus4    = if_id_q.pc_plus4;

  rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_q == WAIT));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    return a + 32'h0050_0093;
  endfunction

  // Memory: accepts when valid&ready, answers with one pulse mem_lat cycles later
  initial begin : mem_model
    logic [31:0] a;
    forever begin
      @(negedge clk); #1;
      if (imem_req_valid && imem_req_ready && rst_n) begin
        a = imem_req_addr;
        @(posedge clk);
        repeat (mem_lat - 1) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_for(a);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic do_reset(input logic rdy, input int lat);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    id_ready = rdy;
    mem_lat = lat;
    rst_n = 1'b1;
  endtask

  task automatic wait_id_valid(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (id_valid === 1'b1) return;
    end
    checks++; failures++;
    $display("FAIL wait_id_valid timeout after %0d cycles", max);
  endtask

  task automatic wait_req_valid(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (imem_req_valid === 1'b1) return;
    end
    checks++; failures++;
    $display("FAIL wait_req_valid timeout after %0d cycles", max);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++; if (id_instr !== NOP) begin failures++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    checks++; if (id_pc_plus4 !== 32'd4) begin failures++; $display("FAIL reset_id_pc_plus4 got=%h exp=4", id_pc_plus4); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    do_reset(1'b1, 1);
    wait_req_valid(5);
    checks++; if (imem_req_addr !== 32'd0) begin failures++; $display("FAIL first_req_addr got=%h exp=0", imem_req_addr); end
    wait_id_valid(10);
    checks++; if (id_instr !== 32'h0050_0093) begin failures++; $display("FAIL first_instr got=%h exp=00500093", id_instr); end
    checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL first_pc got=%h exp=0", id_pc); end
    checks++; if (id_pc_plus4 !== 32'd4) begin failures++; $display("FAIL first_pc_plus4 got=%h exp=4", id_pc_plus4); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd4) begin
      failures++; $display("FAIL first_next_req got=%0b/%h exp=1/4", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      wait_id_valid(10);
      checks++; if (id_pc !== 32'(4 * k) || id_instr !== instr_for(32'(4 * k))) begin
        failures++; $display("FAIL b2b_%0d got=%h@%h exp=%h@%h", k, id_instr, id_pc, instr_for(32'(4 * k)), 32'(4 * k));
      end
    end
  endtask

  task automatic test_hold();
    int reqs;
    do_reset(1'b0, 1);
    wait_id_valid(10);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (imem_req_valid === 1'b1) reqs++;
    end
    checks++; if (reqs !== 1) begin failures++; $display("FAIL hold_req_count got=%0d exp=1", reqs); end
    checks++; if (id_instr !== instr_for(32'd0) || id_pc !== 32'd0 || id_valid !== 1'b1) begin
      failures++; $display("FAIL hold_stable got=%h@%h v=%0b exp=%h@0 v=1", id_instr, id_pc, id_valid, instr_for(32'd0));
    end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL hold_no_req got=%0b exp=0", imem_req_valid); end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd4 || id_instr !== instr_for(32'd4) || id_pc_plus4 !== 32'd8) begin
      failures++; $display("FAIL hold_release got=%0b %h@%h+4=%h exp=1 %h@4+4=8", id_valid, id_instr, id_pc, id_pc_plus4, instr_for(32'd4));
    end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd8) begin
      failures++; $display("FAIL hold_next_req got=%0b/%h exp=1/8", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(1'b1, 3);
    wait_req_valid(5);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rdw_wait got=v%0b/r%0b exp=v0/r0", id_valid, imem_req_valid);
    end
    repeat (2) @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rdw_dropped got=%0b exp=0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin
      failures++; $display("FAIL rdw_next_req got=%0b/%h exp=1/00000100", imem_req_valid, imem_req_addr);
    end
    wait_id_valid(20);
    checks++; if (id_pc !== 32'h0000_0100 || id_instr !== instr_for(32'h0000_0100)) begin
      failures++; $display("FAIL rdw_target got=%h@%h exp=%h@00000100", id_instr, id_pc, instr_for(32'h0000_0100));
    end
  endtask

  task automatic test_redirect_handshake();
    do_reset(1'b1, 1);
    wait_req_valid(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0202;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rdh_wait got=v%0b/r%0b exp=v0/r0", id_valid, imem_req_valid);
    end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rdh_dropped got=%0b exp=0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0200) begin
      failures++; $display("FAIL rdh_next_req got=%0b/%h exp=1/00000200", imem_req_valid, imem_req_addr);
    end
    wait_id_valid(10);
    checks++; if (id_pc !== 32'h0000_0200 || id_instr !== instr_for(32'h0000_0200)) begin
      failures++; $display("FAIL rdh_target got=%h@%h exp=%h@00000200", id_instr, id_pc, instr_for(32'h0000_0200));
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr);
    end
    wait_id_valid(10);
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'd0 || id_instr !== instr_for(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_ifid got=%h@%h+4=%h exp=%h@fffffffc+4=0", id_instr, id_pc, id_pc_plus4, instr_for(32'hFFFF_FFFC));
    end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd0) begin
      failures++; $display("FAIL wrap_next_req got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_in_hold();
    repeat (4) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin
      failures++; $display("FAIL rih_in_hold got=r%0b/v%0b exp=r0/v1", imem_req_valid, id_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin
      failures++; $display("FAIL rih_async got=v%0b/%h exp=v0/%h", id_valid, id_instr, NOP);
    end
    checks++; if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd4 || imem_req_valid !== 1'b0) begin
      failures++; $display("FAIL rih_async_pc got=%h/%h r%0b exp=0/4 r0", id_pc, id_pc_plus4, imem_req_valid);
    end
    repeat (6) @(negedge clk);
    id_ready = 1'b1;
    rst_n = 1'b1;
    wait_req_valid(5);
    checks++; if (imem_req_addr !== 32'd0) begin failures++; $display("FAIL rih_first_req got=%h exp=0", imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_hold();
    test_redirect_wait();
    test_redirect_handshake();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
